led_mode_ctrl: RTL and testbench

Mode and pacing controller that sits directly upstream of the four LED pattern stages (including the bouncing left/right runner). It debounces two push-buttons, steps a 2-bit mode selector and a 2-bit speed selector, and generates the single-cycle `en` step tick and the synchronous `reset` restart pulse that each pattern stage consumes. Only the stage of the selected mode receives ticks.

---
 rtl/led_mode_ctrl.sv | 133 +++++++++++++
 tb/tb_led_mode_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - button debounce, mode/speed selection and step-tick pacing for LED pattern stages
module led_mode_ctrl #(
    parameter int CLK_DIV         = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_speed,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic [3:0] en_mode,
    output logic       restart
);

    // Prescaler must hold 8*CLK_DIV-1 at the slowest speed.
    localparam int PW = $clog2(8 * CLK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0] DB_LIMIT = DW'(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] TERM_S0  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] TERM_S1  = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] TERM_S2  = PW'(4 * CLK_DIV - 1);
    localparam logic [PW-1:0] TERM_S3  = PW'(8 * CLK_DIV - 1);

    // Index 0 is the mode button, index 1 the speed button.
    logic [1:0]          btn_raw;
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0]          deb_dly_q, deb_dly_d;
    logic [1:0][DW-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]          press;

    logic [1:0]          mode_q, mode_d;
    logic [1:0]          speed_q, speed_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [PW-1:0]       term;
    logic                tick;
    logic [3:0]          en_q, en_d;
    logic                restart_q, restart_d;

    assign btn_raw = {btn_speed, btn_mode};

    // Synchronize both buttons and require a run of mismatched samples before accepting a new level.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        db_cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LIMIT) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Press event is a debounced rising edge; releases are ignored.
    assign press = deb_q & ~deb_dly_q;

    // Select the prescaler terminal count for the current speed (speed 0 is fastest).
    always_comb begin
        term = TERM_S0;
        case (speed_q)
            2'd0:    term = TERM_S0;
            2'd1:    term = TERM_S1;
            2'd2:    term = TERM_S2;
            2'd3:    term = TERM_S3;
            default: term = TERM_S0;
        endcase
    end

    // Step mode/speed on presses, run the prescaler and route the tick to the selected stage.
    always_comb begin
        mode_d    = mode_q;
        speed_d   = speed_q;
        pre_d     = pre_q + PW'(1);
        tick      = 1'b0;
        restart_d = press[0];
        if (press[0]) begin
            mode_d = mode_q + 2'd1;
        end
        if (press[1]) begin
            speed_d = speed_q + 2'd1;
        end
        // Any press restarts the period, which also drops a tick that would land on this edge.
        if (|press) begin
            pre_d = '0;
        end else if (pre_q == term) begin
            pre_d = '0;
            tick  = 1'b1;
        end
        en_d = tick ? (4'b0001 << mode_q) : 4'b0000;
    end

    // State registers; restart is held high through reset so the stages start clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            db_cnt_q  <= '0;
            mode_q    <= '0;
            speed_q   <= '0;
            pre_q     <= '0;
            en_q      <= '0;
            restart_q <= 1'b1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            db_cnt_q  <= db_cnt_d;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            pre_q     <= pre_d;
            en_q      <= en_d;
            restart_q <= restart_d;
        end
    end

    assign mode    = mode_q;
    assign speed   = speed_q;
    assign en_mode = en_q;
    assign restart = restart_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - directed self-checking bench for led_mode_ctrl
module tb_led_mode_ctrl;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_speed = 1'b0;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [3:0] en_mode;
    logic       restart;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         restart_pulses = 0;
    logic [1:0] exp_mode = 2'd0;
    logic [1:0] exp_speed = 2'd0;

    led_mode_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_speed(btn_speed),
        .mode(mode), .speed(speed), .en_mode(en_mode), .restart(restart)
    );

    always #5 clk = ~clk;

    // Count restart samples and check restart never coincides with a tick.
    always @(negedge clk) begin
        if (restart) restart_pulses++;
        if (reset && restart) begin
            tests_run++;
            if (en_mode !== 4'b0000) begin
                tests_failed++;
                $display("FAIL overlap: en_mode=%b while restart high, required 0000", en_mode);
            end
        end
    end

    task automatic press(input logic pm, input logic ps);
        btn_mode = pm; btn_speed = ps;
        repeat (10) @(negedge clk);
        btn_mode = 1'b0; btn_speed = 1'b0;
        repeat (12) @(negedge clk);
        if (pm) exp_mode = exp_mode + 2'd1;
        if (ps) exp_speed = exp_speed + 2'd1;
    endtask

    task automatic test_reset;
        reset = 1'b0; btn_mode = 1'b0; btn_speed = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (mode !== 2'd0) begin tests_failed++; $display("FAIL rst_mode got=%0d exp=0", mode); end
        tests_run++; if (speed !== 2'd0) begin tests_failed++; $display("FAIL rst_speed got=%0d exp=0", speed); end
        tests_run++; if (en_mode !== 4'b0000) begin tests_failed++; $display("FAIL rst_en got=%b exp=0000", en_mode); end
        tests_run++; if (restart !== 1'b1) begin tests_failed++; $display("FAIL rst_restart got=%b exp=1", restart); end
        reset = 1'b1;
        #1;
        tests_run++; if (restart !== 1'b1) begin tests_failed++; $display("FAIL rel_restart0 got=%b exp=1", restart); end
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            tests_run++;
            if (restart !== 1'b0) begin tests_failed++; $display("FAIL rel_restart e=%0d got=%b exp=0", e, restart); end
            tests_run++;
            if (en_mode !== ((e % 4 == 0) ? 4'b0001 : 4'b0000)) begin
                tests_failed++; $display("FAIL rel_en e=%0d got=%b exp=%b", e, en_mode, (e % 4 == 0) ? 4'b0001 : 4'b0000);
            end
        end
        tests_run++; if (mode !== 2'd0 || speed !== 2'd0) begin tests_failed++; $display("FAIL rel_sel got=%0d/%0d exp=0/0", mode, speed); end
        exp_mode = 2'd0; exp_speed = 2'd0;
    endtask

    task automatic test_mode_press;
        logic [1:0] em;
        btn_mode = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            em = (i >= 6) ? 2'd1 : 2'd0;
            tests_run++;
            if (mode !== em) begin tests_failed++; $display("FAIL mp_mode i=%0d got=%0d exp=%0d", i, mode, em); end
            if (i >= 6) begin
                tests_run++;
                if (restart !== (i == 6)) begin tests_failed++; $display("FAIL mp_restart i=%0d got=%b exp=%b", i, restart, i == 6); end
            end
            if (i >= 7) begin
                tests_run++;
                if (en_mode !== ((i == 10 || i == 14) ? 4'b0010 : 4'b0000)) begin
                    tests_failed++; $display("FAIL mp_en i=%0d got=%b exp=%b", i, en_mode, (i == 10 || i == 14) ? 4'b0010 : 4'b0000);
                end
            end
            if (i == 9) btn_mode = 1'b0;
        end
        repeat (10) @(negedge clk);
        exp_mode = 2'd1;
        for (int n = 0; n < 3; n++) begin
            press(1'b1, 1'b0);
            tests_run++;
            if (mode !== exp_mode) begin tests_failed++; $display("FAIL mp_wrap n=%0d got=%0d exp=%0d", n, mode, exp_mode); end
        end
    endtask

    task automatic test_glitch;
        int         r0, last, ticks;
        logic [3:0] exp_en;
        bit   [0:15] pat;
        r0 = restart_pulses; last = -1; ticks = 0;
        exp_en = 4'b0001 << exp_mode;
        btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        btn_mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_mode !== 4'b0000) begin
                ticks++;
                tests_run++;
                if (en_mode !== exp_en) begin tests_failed++; $display("FAIL gl_en got=%b exp=%b", en_mode, exp_en); end
                if (last >= 0) begin
                    tests_run++;
                    if (i - last != 4) begin tests_failed++; $display("FAIL gl_gap got=%0d exp=4", i - last); end
                end
                last = i;
            end
        end
        tests_run++; if (ticks != 5) begin tests_failed++; $display("FAIL gl_ticks got=%0d exp=5", ticks); end
        tests_run++; if (mode !== exp_mode) begin tests_failed++; $display("FAIL gl_mode got=%0d exp=%0d", mode, exp_mode); end
        tests_run++; if (restart_pulses != r0) begin tests_failed++; $display("FAIL gl_restart got=%0d exp=0", restart_pulses - r0); end
        pat = 16'b1101101111111111;
        r0 = restart_pulses;
        for (int j = 0; j < 16; j++) begin
            btn_mode = pat[j];
            @(negedge clk);
        end
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        exp_mode = exp_mode + 2'd1;
        tests_run++; if (mode !== exp_mode) begin tests_failed++; $display("FAIL bounce_mode got=%0d exp=%0d", mode, exp_mode); end
        tests_run++; if (restart_pulses - r0 != 1) begin tests_failed++; $display("FAIL bounce_restart got=%0d exp=1", restart_pulses - r0); end
    endtask

    task automatic test_speed;
        int         pers[4];
        int         r0, p;
        bit         first, second;
        logic [3:0] exp_en;
        pers = '{8, 16, 32, 4};
        exp_en = 4'b0001 << exp_mode;
        for (int s = 0; s < 4; s++) begin
            p = pers[s]; r0 = restart_pulses; first = 1'b0; second = 1'b0;
            btn_speed = 1'b1;
            for (int i = 0; i <= 6 + 2 * p + 1; i++) begin
                @(negedge clk);
                if (i == 9) btn_speed = 1'b0;
                if (i >= 7 && en_mode !== 4'b0000) begin
                    tests_run++;
                    if (en_mode !== exp_en) begin tests_failed++; $display("FAIL sp_en got=%b exp=%b", en_mode, exp_en); end
                    if (!first) begin
                        first = 1'b1; tests_run++;
                        if (i != 6 + p) begin tests_failed++; $display("FAIL sp_first P=%0d got=%0d exp=%0d", p, i, 6 + p); end
                    end else if (!second) begin
                        second = 1'b1; tests_run++;
                        if (i != 6 + 2 * p) begin tests_failed++; $display("FAIL sp_second P=%0d got=%0d exp=%0d", p, i, 6 + 2 * p); end
                    end
                end
            end
            exp_speed = exp_speed + 2'd1;
            tests_run++; if (!(first && second)) begin tests_failed++; $display("FAIL sp_ticks P=%0d got=%0d exp=2", p, int'(first) + int'(second)); end
            tests_run++; if (speed !== exp_speed) begin tests_failed++; $display("FAIL sp_speed got=%0d exp=%0d", speed, exp_speed); end
            tests_run++; if (mode !== exp_mode) begin tests_failed++; $display("FAIL sp_mode got=%0d exp=%0d", mode, exp_mode); end
            tests_run++; if (restart_pulses != r0) begin tests_failed++; $display("FAIL sp_restart got=%0d exp=0", restart_pulses - r0); end
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic test_both;
        bit found;
        int r0;
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        press(1'b0, 1'b1); press(1'b0, 1'b1); press(1'b0, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            @(negedge clk);
            if (en_mode !== 4'b0000) found = 1'b1;
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL both_sync_tick got=none exp=tick within 80 cycles"); end
        repeat (25) @(negedge clk);
        r0 = restart_pulses;
        btn_mode = 1'b1; btn_speed = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                tests_run++;
                if (mode !== 2'd3 || speed !== 2'd3) begin tests_failed++; $display("FAIL both_pre got=%0d/%0d exp=3/3", mode, speed); end
            end
            if (i == 6) begin
                tests_run++; if (mode !== 2'd0 || speed !== 2'd0) begin tests_failed++; $display("FAIL both_sel got=%0d/%0d exp=0/0", mode, speed); end
                tests_run++; if (restart !== 1'b1) begin tests_failed++; $display("FAIL both_restart got=%b exp=1", restart); end
                tests_run++; if (en_mode !== 4'b0000) begin tests_failed++; $display("FAIL both_suppress got=%b exp=0000", en_mode); end
            end
            if (i >= 7 && i <= 9) begin
                tests_run++;
                if (en_mode !== 4'b0000 || restart !== 1'b0) begin tests_failed++; $display("FAIL both_quiet i=%0d got=%b/%b exp=0000/0", i, en_mode, restart); end
            end
            if (i == 10) begin
                tests_run++; if (en_mode !== 4'b0001) begin tests_failed++; $display("FAIL both_tick got=%b exp=0001", en_mode); end
            end
            if (i == 9) begin btn_mode = 1'b0; btn_speed = 1'b0; end
        end
        repeat (12) @(negedge clk);
        exp_mode = 2'd0; exp_speed = 2'd0;
        tests_run++; if (restart_pulses - r0 != 1) begin tests_failed++; $display("FAIL both_restart_cnt got=%0d exp=1", restart_pulses - r0); end
    endtask

    task automatic test_reset_mid;
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1);
        tests_run++; if (mode !== 2'd2 || speed !== 2'd1) begin tests_failed++; $display("FAIL rm_setup got=%0d/%0d exp=2/1", mode, speed); end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        tests_run++; if (mode !== 2'd0 || speed !== 2'd0) begin tests_failed++; $display("FAIL rm_async_sel got=%0d/%0d exp=0/0", mode, speed); end
        tests_run++; if (en_mode !== 4'b0000) begin tests_failed++; $display("FAIL rm_async_en got=%b exp=0000", en_mode); end
        tests_run++; if (restart !== 1'b1) begin tests_failed++; $display("FAIL rm_async_restart got=%b exp=1", restart); end
        repeat (2) @(negedge clk);
        tests_run++; if (restart !== 1'b1 || mode !== 2'd0) begin tests_failed++; $display("FAIL rm_hold got=%b/%0d exp=1/0", restart, mode); end
        reset = 1'b1;
        #1;
        tests_run++; if (restart !== 1'b1) begin tests_failed++; $display("FAIL rm_rel_restart0 got=%b exp=1", restart); end
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            tests_run++;
            if (restart !== 1'b0) begin tests_failed++; $display("FAIL rm_restart e=%0d got=%b exp=0", e, restart); end
            tests_run++;
            if (en_mode !== ((e % 4 == 0) ? 4'b0001 : 4'b0000)) begin
                tests_failed++; $display("FAIL rm_en e=%0d got=%b exp=%b", e, en_mode, (e % 4 == 0) ? 4'b0001 : 4'b0000);
            end
        end
        tests_run++; if (mode !== 2'd0 || speed !== 2'd0) begin tests_failed++; $display("FAIL rm_sel got=%0d/%0d exp=0/0", mode, speed); end
        exp_mode = 2'd0; exp_speed = 2'd0;
    endtask

    initial begin
        test_reset();
        test_mode_press();
        test_glitch();
        test_speed();
        test_both();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
